// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam int DM_BURST_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch, data) in front of a single-port memory.
// Data has priority, but fetch wins after DM_BURST_MAX back-to-back data grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DM_BURST_MAX = DM_BURST_MAX_DEF,
  parameter int MEM_AW       = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [MEM_AW-1:0] if_addr_i,
  output logic [31:0]       if_rdata_o,
  output logic              if_ready_o,
  input  logic              dm_req_i,
  input  logic [3:0]        dm_w_en_i,
  input  logic [MEM_AW-1:0] dm_addr_i,
  input  logic [31:0]       dm_wdata_i,
  output logic [31:0]       dm_rdata_o,
  output logic              dm_ready_o,
  output logic              mem_req_o,
  output logic [3:0]        mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              spurious_ack_o
);

  localparam int            CW      = $clog2(DM_BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DM_BURST_MAX);

  arb_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              gnt_dm_q, gnt_dm_d;
  logic              mem_req_q, mem_req_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic              spur_q, spur_d;
  logic              pick_dm;

  // Fetch only overrides data once the burst allowance is used up.
  assign pick_dm = dm_req_i && !(if_req_i && (cnt_q == CNT_MAX));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_dm_d    = gnt_dm_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    spur_d      = spur_q | (mem_ack_i && (state_q != ST_BUSY));

    case (state_q)
      ST_IDLE: begin
        if (if_req_i || dm_req_i) begin
          state_d   = ST_BUSY;
          mem_req_d = 1'b1;
          gnt_dm_d  = pick_dm;
          if (pick_dm) begin
            mem_addr_d  = dm_addr_i;
            mem_we_d    = dm_w_en_i;
            mem_wdata_d = dm_wdata_i;
            if (!if_req_i)             cnt_d = '0;
            else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
          end else begin
            mem_addr_d  = if_addr_i;
            mem_we_d    = 4'b0000;
            mem_wdata_d = '0;
            cnt_d       = '0;
          end
        end
      end
      ST_BUSY: begin
        if (mem_ack_i) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          if (gnt_dm_q) begin
            dm_ready_d = 1'b1;
            // stores keep the previous load result visible
            if (mem_we_q == 4'b0000) dm_rdata_d = mem_rdata_i;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gnt_dm_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      spur_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_dm_q    <= gnt_dm_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      spur_q      <= spur_d;
    end
  end

  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign if_rdata_o     = if_rdata_q;
  assign dm_rdata_o     = dm_rdata_q;
  assign if_ready_o     = if_ready_q;
  assign dm_ready_o     = dm_ready_q;
  assign spurious_ack_o = spur_q;
  assign stall_o        = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random fetch/data traffic against a memory
// responder, with grant order and response data predicted from arbitration rules.
module tb_mem_arbiter;

  localparam int BMAX = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ready_o;
  logic        dm_req_i;
  logic [3:0]  dm_w_en_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ready_o;
  logic        mem_req_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        stall_o;
  logic        spurious_ack_o;

  mem_arbiter #(.DM_BURST_MAX(BMAX), .MEM_AW(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .dm_req_i(dm_req_i), .dm_w_en_i(dm_w_en_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o), .spurious_ack_o(spurious_ack_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // responder memory (driven by what the DUT asks for) and reference memory
  logic [31:0] rmem    [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  function automatic logic [31:0] ref_rd(input logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  // ---------------- memory responder ----------------
  int fix_lat = 0;
  bit resp_en = 1'b1;

  initial begin
    int          lat;
    logic [29:0] w;
    logic [31:0] cur;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (resp_en && rst_ni && mem_req_o) begin
        lat = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 3));
        repeat (lat) @(negedge clk_i);
        w   = mem_addr_o[31:2];
        cur = rmem.exists(w) ? rmem[w] : init_word(w);
        mem_rdata_i = cur;
        for (int b = 0; b < 4; b++)
          if (mem_we_o[b]) cur[8*b +: 8] = mem_wdata_o[8*b +: 8];
        if (mem_we_o != 4'b0000) rmem[w] = cur;
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
      end
    end
  end

  // ---------------- scoreboard queues ----------------
  logic [31:0] fq[$];
  logic [31:0] dq[$];
  logic [31:0] exp_dm = '0;

  task automatic do_fetch(input logic [31:0] a);
    int c;
    if_addr_i = a;
    if_req_i  = 1'b1;
    fq.push_back(ref_rd(a[31:2]));
    for (c = 0; c < 100; c++) begin
      @(posedge clk_i); #1;
      if (if_ready_o) break;
    end
    if (c == 100) begin errors++; $display("FAIL fetch_timeout: no if_ready for addr %h", a); end
    if_req_i = 1'b0;
  endtask

  task automatic do_data(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    int c;
    logic [31:0] cur;
    if (we == 4'b0000) exp_dm = ref_rd(a[31:2]);
    else begin
      cur = ref_rd(a[31:2]);
      for (int b = 0; b < 4; b++) if (we[b]) cur[8*b +: 8] = wd[8*b +: 8];
      ref_mem[a[31:2]] = cur;
    end
    dq.push_back(exp_dm);
    dm_addr_i = a; dm_w_en_i = we; dm_wdata_i = wd; dm_req_i = 1'b1;
    for (c = 0; c < 100; c++) begin
      @(posedge clk_i); #1;
      if (dm_ready_o) break;
    end
    if (c == 100) begin errors++; $display("FAIL data_timeout: no dm_ready for addr %h", a); end
    dm_req_i = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic        prev_mreq = 1'b0, p_if = 1'b0, p_dm = 1'b0;
  logic [31:0] p_ia, p_da, p_dw;
  logic [3:0]  p_dwe;
  logic [31:0] h_addr, h_wd;
  logic [3:0]  h_we;
  bit          h_dm;
  int          cnt_m = 0;
  int          dm_pulses = 0;
  int          if_pulses = 0;
  string       glog = "";

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      cnt_m = 0; prev_mreq = 1'b0; p_if = 1'b0; p_dm = 1'b0;
    end else begin
      if (if_ready_o) begin
        if_pulses++;
        if (fq.size() == 0) begin errors++; checks++; $display("FAIL if_ready_unexpected: got 1 expected 0"); end
        else chk("if_rdata", if_rdata_o, fq.pop_front());
      end
      if (dm_ready_o) begin
        dm_pulses++;
        if (dq.size() == 0) begin errors++; checks++; $display("FAIL dm_ready_unexpected: got 1 expected 0"); end
        else chk("dm_rdata", dm_rdata_o, dq.pop_front());
      end
      chk("stall", 32'(stall_o), 32'((if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o)));
      if (mem_req_o && !prev_mreq) begin
        if (!p_if && !p_dm) begin errors++; checks++; $display("FAIL grant_noreq: mem_req rose with no request"); end
        else begin
          h_dm   = p_dm && !(p_if && cnt_m == BMAX);
          h_addr = h_dm ? p_da : p_ia;
          h_we   = h_dm ? p_dwe : 4'b0000;
          h_wd   = p_dw;
          if (h_dm) cnt_m = p_if ? ((cnt_m < BMAX) ? cnt_m + 1 : cnt_m) : 0;
          else      cnt_m = 0;
          glog = {glog, (mem_addr_o >= 32'h1000) ? "D" : "F"};
        end
      end
      if (mem_req_o) begin
        chk("mem_addr", mem_addr_o, h_addr);
        chk("mem_we", 32'(mem_we_o), 32'(h_we));
        if (h_dm && h_we != 4'b0000) chk("mem_wdata", mem_wdata_o, h_wd);
      end
      prev_mreq = mem_req_o;
      p_if = if_req_i; p_dm = dm_req_i;
      p_ia = if_addr_i; p_da = dm_addr_i; p_dw = dm_wdata_i; p_dwe = dm_w_en_i;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},   32'(mem_req_o), 32'd0);
    chk({tag, "_mem_we"},    32'(mem_we_o), 32'd0);
    chk({tag, "_mem_addr"},  mem_addr_o, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    chk({tag, "_if_rdata"},  if_rdata_o, 32'd0);
    chk({tag, "_dm_rdata"},  dm_rdata_o, 32'd0);
    chk({tag, "_if_ready"},  32'(if_ready_o), 32'd0);
    chk({tag, "_dm_ready"},  32'(dm_ready_o), 32'd0);
    chk({tag, "_spurious"},  32'(spurious_ack_o), 32'd0);
  endtask

  initial begin
    repeat (20000) @(posedge clk_i);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int n0, p0, q0, c;
    rst_ni = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_w_en_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // single fetch, ack two cycles after mem_req
    rmem[30'h40] = 32'h0050_0093; ref_mem[30'h40] = 32'h0050_0093;
    fix_lat = 2; p0 = dm_pulses;
    do_fetch(32'h100);
    chk("fetch_ifrdata", if_rdata_o, 32'h0050_0093);
    @(negedge clk_i);
    chk("fetch_no_dmready", 32'(dm_pulses - p0), 32'd0);
    @(posedge clk_i); #1;
    fix_lat = 0;

    // simultaneous store and fetch: data first
    n0 = glog.len();
    fork
      do_data(32'h2000, 4'hF, 32'hDEAD_BEEF);
      do_fetch(32'h104);
    join
    @(negedge clk_i);
    chk("sim_order_len", 32'(glog.len() - n0), 32'd2);
    if (glog.len() >= n0 + 2) chk("sim_order_first", 32'(glog[n0]), 32'("D"));
    @(posedge clk_i); #1;

    // load at a byte offset returns the stored word
    do_data(32'h2003, 4'h0, 32'h0);
    chk("load_after_store", dm_rdata_o, 32'hDEAD_BEEF);

    // six back-to-back loads against a waiting fetch
    n0 = glog.len();
    fork
      do_fetch(32'h200);
      for (int i = 0; i < 6; i++) do_data(32'h2000 + 32'(4 * i), 4'h0, 32'h0);
    join
    @(negedge clk_i);
    chk("burst_len", 32'(glog.len() - n0), 32'd7);
    if (glog.len() >= n0 + 6) begin
      chk("burst_order", 32'(glog.substr(n0, n0 + 5) == "DDDDFD"), 32'd1);
    end
    @(posedge clk_i); #1;

    // requester drops dm_req one cycle after grant
    fix_lat = 3; p0 = dm_pulses;
    exp_dm = ref_rd(30'h804);
    dq.push_back(exp_dm);
    dm_addr_i = 32'h2010; dm_w_en_i = 4'h0; dm_req_i = 1'b1;
    for (c = 0; c < 20 && !mem_req_o; c++) begin @(posedge clk_i); #1; end
    if (c == 20) begin errors++; $display("FAIL drop_grant_timeout: mem_req never rose"); end
    @(posedge clk_i); #1;
    dm_req_i = 1'b0;
    @(negedge clk_i);
    chk("drop_memreq_held", 32'(mem_req_o), 32'd1);
    repeat (8) @(posedge clk_i);
    #1;
    chk("drop_one_pulse", 32'(dm_pulses - p0), 32'd1);
    fix_lat = 0;

    // randomized traffic
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk_i); #1; end
        do_fetch(32'($urandom_range(0, 32'hFFF)) & 32'hFFFF_FFFC);
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk_i); #1; end
        if ($urandom_range(0, 1) == 0) do_data(32'h2000 + $urandom_range(0, 63), 4'h0, 32'h0);
        else do_data(32'h2000 + $urandom_range(0, 63), 4'($urandom_range(1, 15)), $urandom);
      end
    join
    repeat (3) @(posedge clk_i);
    #1;
    chk("rand_fq_empty", 32'(fq.size()), 32'd0);
    chk("rand_dq_empty", 32'(dq.size()), 32'd0);
    chk("rand_no_spurious", 32'(spurious_ack_o), 32'd0);

    // reset mid-transaction, stale ack afterwards
    resp_en = 1'b0;
    dm_addr_i = 32'h2020; dm_w_en_i = 4'h0; dm_req_i = 1'b1;
    for (c = 0; c < 20 && !mem_req_o; c++) begin @(posedge clk_i); #1; end
    if (c == 20) begin errors++; $display("FAIL rst_grant_timeout: mem_req never rose"); end
    @(posedge clk_i); #1;
    rst_ni = 1'b0; dm_req_i = 1'b0;
    #1;
    chk_all_zero("busy_reset");
    @(negedge clk_i) rst_ni = 1'b1;
    p0 = dm_pulses; q0 = if_pulses;
    @(negedge clk_i) mem_ack_i = 1'b1;
    @(negedge clk_i) mem_ack_i = 1'b0;
    chk("stale_ack_spurious", 32'(spurious_ack_o), 32'd1);
    repeat (4) @(negedge clk_i);
    chk("stale_ack_no_ready", 32'(dm_pulses - p0 + if_pulses - q0), 32'd0);
    chk("stale_ack_memreq", 32'(mem_req_o), 32'd0);
    chk("stale_ack_sticky", 32'(spurious_ack_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
